// File: rtl/rtc_apb_pkg.sv
// Shared types and RTC register map for the RTC APB initiator.
package rtc_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERR    = 2'd3
    } apb_state_t;

    localparam logic [11:0] RTCDR   = 12'h200;
    localparam logic [11:0] RTCMR   = 12'h204;
    localparam logic [11:0] RTCLR   = 12'h208;
    localparam logic [11:0] RTCCR   = 12'h20C;
    localparam logic [11:0] RTCIMSC = 12'h210;
    localparam logic [11:0] RTCRIS  = 12'h214;
    localparam logic [11:0] RTCMIS  = 12'h218;
    localparam logic [11:0] RTCICR  = 12'h21C;

    function automatic logic addr_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/rtc_apb_initiator_if.sv
// APB3 bus bundle between the initiator and the RTC register bank.
interface rtc_apb_initiator_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the ACCESS phase; flags the stalled cycle that reaches LIMIT.
module apb_wait_timer #(
    parameter int unsigned LIMIT = 64
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Fires on the stalled edge that would bring the count to LIMIT; LIMIT=0 never fires.
    assign expired = (LIMIT != 0) && enable && (count == LAST);

endmodule

// File: rtl/rtc_apb_initiator.sv
// APB3 requester: turns single-beat valid/ready commands into SETUP/ACCESS transfers
// toward the RTC register bank and reports each outcome as a one-cycle response pulse.
//
//  state  | meaning
//  IDLE   | ready for a command, bus idle (PSEL=0)
//  SETUP  | APB setup phase, PSEL=1 PENABLE=0, wait timer cleared
//  ACCESS | APB access phase, waiting on PREADY or timeout
//  ERR    | misaligned command rejected without a bus transfer
module rtc_apb_initiator
    import rtc_apb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,

    rtc_apb_initiator_if.master   apb
);
    apb_state_t state;
    logic       wait_expired;

    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (state == SETUP),
        .enable  ((state == ACCESS) && !apb.PREADY),
        .expired (wait_expired)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (addr_aligned(cmd_addr[1:0])) begin
                            state      <= SETUP;
                            apb.PSEL   <= 1'b1;
                            apb.PWRITE <= cmd_write;
                            apb.PADDR  <= cmd_addr;
                            apb.PWDATA <= cmd_write ? cmd_wdata : '0;
                        end else begin
                            state <= ERR;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    apb.PENABLE <= 1'b1;
                end
                ACCESS: begin
                    // PREADY takes priority over a timeout landing on the same edge.
                    if (apb.PREADY) begin
                        state       <= IDLE;
                        cmd_ready   <= 1'b1;
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= apb.PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!apb.PWRITE && !apb.PSLVERR) ? apb.PRDATA : '0;
                    end else if (wait_expired) begin
                        state       <= IDLE;
                        cmd_ready   <= 1'b1;
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end
                end
                ERR: begin
                    state       <= IDLE;
                    cmd_ready   <= 1'b1;
                    rsp_valid   <= 1'b1;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b0;
                    rsp_rdata   <= '0;
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready   <= 1'b0;
                    apb.PSEL    <= 1'b0;
                    apb.PENABLE <= 1'b0;
                end
            endcase
        end
    end

endmodule
